morse_uart_tx: RTL and testbench
================================

# morse_uart_tx

Downstream consumer of the Morse decoder: captures each decoded letter, buffers it in a small FIFO and serialises it as 8N1 UART (optionally 8E1) on a single TX pin for a host terminal. It sits directly after the decoder's letter/done outputs and needs no handshake back to the decoder. Letters arriving faster than the line can drain are queued; letters arriving while the FIFO is full are dropped and flagged.

## Interface
- CLKS_PER_BIT, default 434: clk cycles per UART bit, minimum 2.
- FIFO_DEPTH, default 8: letter slots, power of two, minimum 2.
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high.
- letter  in  8  decoded character (ASCII); valid in any cycle where done is high.
- done  in  1  decoder completion flag; a level that may stay high for several cycles.
- tx  out  1  UART line, idle high.
- busy  out  1  high while the FIFO is non-empty or a frame is in flight.
- overflow  out  1  one-cycle pulse when a letter is dropped.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied slots.

## Operation
- Reset values: tx=1, busy=0, overflow=0, fifo_count=0. The FIFO pointers clear and the FSM goes to IDLE.
- Capture: done is registered as done_q. A push is requested when done && !done_q (rising edge), using the letter value in that same cycle. A done held high produces exactly one push.
- FIFO:
  - Circular buffer with rd/wr pointers one bit wider than the address.
  - full when the address bits are equal and the MSBs differ; empty when the pointers are equal.
  - Pointers wrap modulo 2*FIFO_DEPTH.
- Push while full with no pop in the same cycle: the letter is dropped, overflow pulses, and the FIFO is unchanged.
- Push and pop in the same cycle: both happen even when the FIFO is full. fifo_count is unchanged.
- Pop while empty: cannot occur, because the FSM only pops when the FIFO is non-empty.
- TX FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop into shift register sh[7:0] and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=sh[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then sh shifts right. After bit 7, go to PARITY if enabled, otherwise STOP.
  - PARITY: tx = even parity of the popped byte (XOR of its 8 bits), for CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- IDLE pops on the cycle it is entered from STOP if data is waiting. Back-to-back frames therefore have no extra idle bit.
- Baud counter: counts 0..CLKS_PER_BIT-1. It resets to 0 on every state or bit change. Width is $clog2(CLKS_PER_BIT).
- tx is driven from a register, so there is no combinational glitching.
- busy = (state != IDLE) || !empty.

## Timing
- Cycle T is the first cycle with done=1 after done=0.
- Letter is written into the FIFO at the edge ending T.
- With the FSM IDLE, the pop happens at the edge ending T+1, and tx=0 is visible from cycle T+2.
- Frame length is 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- overflow is high only in cycle T+1 for the rejected letter.
- fifo_count updates one cycle after the push or pop edge.
- Reset asserted mid-frame: tx=1 in the cycle after reset is sampled. The queued letters and the partial frame are discarded. A done held high through reset release does not push, because done_q is reset to 1.

## Configuration
- MORSE_UART_PARITY_EN defined: the PARITY state is compiled in and frames are 8E1.
- Not defined: the PARITY state and its logic are absent, frames are 8N1, and DATA goes directly to STOP.

## Structure
- Shared header morse_defs.vh holds:
  - TX state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4).
  - ASCII range constants.
  - The MORSE_UART_PARITY_EN default, which is left undefined.
- Sub-module morse_letter_fifo (parameters WIDTH, DEPTH) holds storage, pointers, full/empty and count. It is reusable for other queues.
- The top level holds the edge detect, the TX FSM and the baud counter.

## Test plan
- Single letter: CLKS_PER_BIT=4. letter=8'h53 ('S') with done high for 3 cycles.
  - Expected: one frame with tx=0 from T+2, data bits 1,1,0,0,1,0,1,0 at 4 cycles each, then stop=1.
  - busy drops to 0 at the end of the frame.
- Back-to-back: push 'A' and 'B' 5 cycles apart.
  - Expected: two consecutive frames with no idle gap; fifo_count goes 1→0→1→0.
- Overflow: FIFO_DEPTH=4, CLKS_PER_BIT=16. Push 6 letters quickly.
  - Expected: the first letter goes straight into flight, the next 4 queue, and the 6th pulses overflow once.
  - Output order is preserved.
- Wrap-around: stream 20 letters with gaps longer than one frame.
  - Expected: all 20 are received in order and the pointers wrap without loss.
- Reset mid-frame: assert reset during DATA bit 3 with 2 letters queued.
  - Expected: tx=1 the next cycle, fifo_count=0, and no further frames.
- Parity, with MORSE_UART_PARITY_EN defined: send 8'h45.
  - Expected: parity bit 1 and an 11-bit frame. Without the macro, a 10-bit frame.

Source files
------------

// File: rtl/morse_uart_tx_pkg.sv
// ============================================================================
// morse_uart_tx_pkg : shared TX state encodings, ASCII constants, helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package morse_uart_tx_pkg;

    localparam int          STATE_W       = 3;
    localparam logic [2:0]  ST_IDLE       = 3'd0;
    localparam logic [2:0]  ST_START      = 3'd1;
    localparam logic [2:0]  ST_DATA       = 3'd2;
    localparam logic [2:0]  ST_PARITY     = 3'd3;
    localparam logic [2:0]  ST_STOP       = 3'd4;

    localparam logic [7:0]  ASCII_SPACE   = 8'h20;
    localparam logic [7:0]  ASCII_DIGIT_0 = 8'h30;
    localparam logic [7:0]  ASCII_DIGIT_9 = 8'h39;
    localparam logic [7:0]  ASCII_UPPER_A = 8'h41;
    localparam logic [7:0]  ASCII_UPPER_Z = 8'h5A;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/morse_uart_tx_if.sv
// ============================================================================
// morse_uart_tx_if : decoder-side letter input and UART/status outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface morse_uart_tx_if #(
    parameter int FIFO_DEPTH = 8
);
    logic [7:0]                  letter;
    logic                        done;
    logic                        tx;
    logic                        busy;
    logic                        overflow;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    modport master (
        output letter, done,
        input  tx, busy, overflow, fifo_count
    );

    modport slave (
        input  letter, done,
        output tx, busy, overflow, fifo_count
    );
endinterface

`default_nettype wire

// File: rtl/morse_uart_tx_fifo.sv
// ============================================================================
// morse_letter_fifo : generic circular FIFO, pointers one bit wider than addr
// Rev 1.0
// ============================================================================
`default_nettype none

module morse_letter_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     push_i,
    input  wire logic [WIDTH-1:0]         wdata_i,
    input  wire logic                     pop_i,
    output logic      [WIDTH-1:0]         rdata_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic      [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;

    assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign empty_o = (wr_q == rd_q);
    assign count_o = wr_q - rd_q;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    // A pop frees the slot this same edge, so a full FIFO still accepts a push
    assign do_push = push_i && (!full_o || pop_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (pop_i)   rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/morse_uart_tx.sv
// ============================================================================
// morse_uart_tx : queues decoded Morse letters and sends them as UART 8N1.
// Define MORSE_UART_PARITY_EN to compile in the even-parity bit (8E1).
// Rev 1.0
// ============================================================================
`default_nettype none

module morse_uart_tx
    import morse_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    morse_uart_tx_if.slave  bus
);
    localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         sh_q, sh_d;
    logic               tx_q, tx_d;
    logic               done_q;
    logic               ovf_q, ovf_d;
`ifdef MORSE_UART_PARITY_EN
    logic               par_q, par_d;
`endif

    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [7:0]         rdata;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic               baud_end;

    assign push     = bus.done && !done_q;
    assign ovf_d    = push && full && !pop;
    assign baud_end = (baud_q == BAUD_LAST);

    morse_letter_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (bus.letter),
        .pop_i   (pop),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // tx_d follows the next state so the line changes on the same edge as the FSM
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef MORSE_UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = rdata;
`ifdef MORSE_UART_PARITY_EN
                    par_d   = even_parity(rdata);
`endif
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                    tx_d    = sh_q[0];
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    sh_d   = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef MORSE_UART_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = par_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = sh_q[1];
                    end
                end
            end
`ifdef MORSE_UART_PARITY_EN
            ST_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // done_q resets high so a done level held across reset release is not a new letter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b1;
            ovf_q   <= 1'b0;
`ifdef MORSE_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            done_q  <= bus.done;
            ovf_q   <= ovf_d;
`ifdef MORSE_UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = (state_q != ST_IDLE) || !empty;
    assign bus.overflow   = ovf_q;
    assign bus.fifo_count = count;

endmodule

`default_nettype wire

// File: tb/tb_morse_uart_tx.sv
// ============================================================================
// tb_morse_uart_tx : directed self-checking bench, CLKS_PER_BIT=4, depth 4
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_morse_uart_tx;
    localparam int C     = 4;
    localparam int DEPTH = 4;
`ifdef MORSE_UART_PARITY_EN
    localparam int NB    = 11;
`else
    localparam int NB    = 10;
`endif

    logic clk;
    logic reset;
    morse_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    morse_uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] got [$];
    logic       rx_en;
    int         ovf_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic pulse(input logic [7:0] v);
        @(posedge clk); #1 bus.letter = v; bus.done = 1'b1;
        @(posedge clk); #1 bus.done = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int i = 0;
        while (got.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("rx_timeout", 32'(got.size() >= n), 32'd1);
    endtask

    function automatic logic [31:0] got_at(input int idx);
        return (idx < got.size()) ? 32'(got[idx]) : 32'hDEAD;
    endfunction

    always @(negedge clk) if (bus.overflow) ovf_cnt <= ovf_cnt + 1;

    // Independent UART receiver: mid-bit sampling after a falling start edge
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rx_en && bus.tx == 1'b0) begin
                repeat (C/2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (C) @(negedge clk);
                    b[k] = bus.tx;
                end
`ifdef MORSE_UART_PARITY_EN
                repeat (C) @(negedge clk);
                chk("rx_parity", 32'(bus.tx), 32'(^b));
`endif
                repeat (C) @(negedge clk);
                chk("rx_stop", 32'(bus.tx), 32'd1);
                got.push_back(b);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s_bits;
        int base;
        int lows;
        int ovf0;
        s_bits = 8'h53;

        reset = 1'b1; bus.done = 1'b0; bus.letter = 8'h00; rx_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_tx",    32'(bus.tx), 32'd1);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_ovf",   32'(bus.overflow), 32'd0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);

        // Single letter 'S', done held 3 cycles
        base = got.size();
        @(posedge clk); #1 bus.letter = 8'h53; bus.done = 1'b1;
        fork
            begin repeat (3) @(posedge clk); #1 bus.done = 1'b0; end
        join_none
        @(negedge clk);
        chk("s_T_count", 32'(bus.fifo_count), 32'd0);
        chk("s_T_tx",    32'(bus.tx), 32'd1);
        @(negedge clk);
        chk("s_T1_count", 32'(bus.fifo_count), 32'd1);
        chk("s_T1_busy",  32'(bus.busy), 32'd1);
        chk("s_T1_tx",    32'(bus.tx), 32'd1);
        @(negedge clk);
        chk("s_start", 32'(bus.tx), 32'd0);
        chk("s_T2_count", 32'(bus.fifo_count), 32'd0);
        for (int k = 0; k < 8; k++) begin
            repeat (C) @(negedge clk);
            chk($sformatf("s_bit%0d", k), 32'(bus.tx), 32'(s_bits[k]));
        end
`ifdef MORSE_UART_PARITY_EN
        repeat (C) @(negedge clk);
        chk("s_parity", 32'(bus.tx), 32'd0);
`endif
        repeat (C) @(negedge clk);
        chk("s_stop", 32'(bus.tx), 32'd1);
        repeat (C-1) @(negedge clk);
        chk("s_busy_last", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("s_busy_end", 32'(bus.busy), 32'd0);
        chk("s_one_push", 32'(bus.fifo_count), 32'd0);
        wait_rx(base + 1, 20);
        chk("s_data", got_at(base), 32'h53);
        repeat (5) @(negedge clk);
        chk("s_no_dup", 32'(got.size()), 32'(base + 1));

        // Back-to-back 'A' then 'B' five cycles later
        base = got.size();
        @(posedge clk); #1 bus.letter = 8'h41; bus.done = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 bus.done = 1'b0;
        @(negedge clk);
        chk("bb_cnt_T1", 32'(bus.fifo_count), 32'd1);
        @(negedge clk);
        chk("bb_cnt_T2", 32'(bus.fifo_count), 32'd0);
        repeat (3) @(posedge clk);
        #1 bus.letter = 8'h42; bus.done = 1'b1;
        @(posedge clk); #1 bus.done = 1'b0;
        @(negedge clk);
        chk("bb_cnt_T6", 32'(bus.fifo_count), 32'd1);
        repeat (NB*C - 4) @(negedge clk);
        chk("bb_idle_cnt", 32'(bus.fifo_count), 32'd1);
        chk("bb_idle_tx",  32'(bus.tx), 32'd1);
        @(negedge clk);
        chk("bb_pop_cnt",  32'(bus.fifo_count), 32'd0);
        chk("bb_start_tx", 32'(bus.tx), 32'd0);
        wait_rx(base + 2, NB*C + 20);
        chk("bb_first",  got_at(base),     32'h41);
        chk("bb_second", got_at(base + 1), 32'h42);

        // Overflow: six rapid letters into a depth-4 FIFO
        base = got.size();
        ovf0 = ovf_cnt;
        for (int i = 0; i < 5; i++) pulse(8'h31 + 8'(i));
        @(posedge clk); #1 bus.letter = 8'h36; bus.done = 1'b1;
        @(negedge clk);
        chk("ov_full_cnt", 32'(bus.fifo_count), 32'd4);
        chk("ov_pre",      32'(bus.overflow), 32'd0);
        @(posedge clk); #1 bus.done = 1'b0;
        @(negedge clk);
        chk("ov_pulse",    32'(bus.overflow), 32'd1);
        chk("ov_cnt_keep", 32'(bus.fifo_count), 32'd4);
        @(negedge clk);
        chk("ov_post",     32'(bus.overflow), 32'd0);
        wait_rx(base + 5, 6*(NB*C + 2) + 20);
        for (int i = 0; i < 5; i++)
            chk($sformatf("ov_order%0d", i), got_at(base + i), 32'h31 + i);
        repeat (2*NB*C) @(negedge clk);
        chk("ov_dropped", 32'(got.size()), 32'(base + 5));
        chk("ov_once",    32'(ovf_cnt - ovf0), 32'd1);

        // Wrap-around: 20 letters spaced beyond a frame
        base = got.size();
        for (int i = 0; i < 20; i++) begin
            pulse(8'h41 + 8'(i));
            repeat (NB*C + 10) @(posedge clk);
        end
        wait_rx(base + 20, 2*NB*C);
        for (int i = 0; i < 20; i++)
            chk($sformatf("wrap%0d", i), got_at(base + i), 32'h41 + i);
        chk("wrap_idle", 32'(bus.busy), 32'd0);

        // Reset during DATA bit 3 with two letters queued
        rx_en = 1'b0;
        repeat (4) @(posedge clk);
        pulse(8'hF7);
        pulse(8'h11);
        pulse(8'h22);
        repeat (4*C - 2) @(posedge clk);
        #1 reset = 1'b1; bus.done = 1'b1;
        @(negedge clk);
        chk("rm_bit3",  32'(bus.tx), 32'd0);
        chk("rm_queue", 32'(bus.fifo_count), 32'd2);
        @(posedge clk);
        @(negedge clk);
        chk("rm_tx",    32'(bus.tx), 32'd1);
        chk("rm_count", 32'(bus.fifo_count), 32'd0);
        chk("rm_busy",  32'(bus.busy), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rm_no_push", 32'(bus.fifo_count), 32'd0);
        @(posedge clk); #1 bus.done = 1'b0;
        lows = 0;
        for (int i = 0; i < 12*C; i++) begin
            @(negedge clk);
            if (bus.tx == 1'b0) lows++;
        end
        chk("rm_silent", 32'(lows), 32'd0);
        rx_en = 1'b1;

        // Frame length / parity with 8'h45
        base = got.size();
        @(posedge clk); #1 bus.letter = 8'h45; bus.done = 1'b1;
        @(posedge clk); #1 bus.done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("p_start", 32'(bus.tx), 32'd0);
        repeat (9*C) @(negedge clk);
`ifdef MORSE_UART_PARITY_EN
        chk("p_parity", 32'(bus.tx), 32'd1);
`else
        chk("p_stop", 32'(bus.tx), 32'd1);
`endif
        repeat ((NB - 9)*C - 1) @(negedge clk);
        chk("p_len_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("p_len_end",  32'(bus.busy), 32'd0);
        wait_rx(base + 1, 20);
        chk("p_data", got_at(base), 32'h45);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
